// File: rtl/tnn_pkg.sv
// Shared types for the TNN classifier front-end: feature sizing, vector type and sequencer states.
package tnn_pkg;

    localparam int unsigned FEAT_W = 3;
    localparam int unsigned N_FEAT = 6;

    typedef logic [FEAT_W-1:0]  feat_t;
    typedef feat_t [N_FEAT-1:0] feat_vec_t;

    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
        HOLD
    } state_t;

endpackage

// File: rtl/tnn_result_hold.sv
// Output holding register: captures one decision, presents it over valid/ready
// and advances the sample index on each consume.
module tnn_result_hold #(
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_class,
    input  logic             load_err,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_class,
    output logic             out_err,
    output logic [IDX_W-1:0] out_idx
);

    logic consume;

    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_class <= 1'b0;
            out_err   <= 1'b0;
            out_idx   <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_class <= load_class;
                out_err   <= load_err;
            end else if (consume) begin
                out_valid <= 1'b0;
                out_idx   <= out_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tnn_sample_sequencer.sv
// Per-core front-end: assembles six 3-bit features, drives the core, waits CLS_LAT
// cycles and returns the sampled decision with index and framing-error flag.
module tnn_sample_sequencer
    import tnn_pkg::*;
#(
    parameter int unsigned CLS_LAT = 1,
    parameter int unsigned IDX_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_feat,
    input  logic              in_last,
    output logic [FEAT_W-1:0] feat_a,
    output logic [FEAT_W-1:0] feat_b,
    output logic [FEAT_W-1:0] feat_c,
    output logic [FEAT_W-1:0] feat_d,
    output logic [FEAT_W-1:0] feat_e,
    output logic [FEAT_W-1:0] feat_f,
    input  logic              cls_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic              out_err,
    output logic [IDX_W-1:0]  out_idx
);

    localparam logic [2:0] LAST_SLOT = 3'(N_FEAT - 1);
    localparam logic [3:0] LAT_M1    = 4'(CLS_LAT - 1);

    state_t     state, state_nxt;
    feat_vec_t  slots;
    logic [2:0] ptr;
    logic [3:0] cnt;
    logic       err_q;
    logic       accept;
    logic       frame_end;
    logic       load;

    // Gate with rst_n so no beat looks accepted while reset is held.
    assign in_ready  = (state == COLLECT) & rst_n;
    assign accept    = in_valid & in_ready;
    assign frame_end = accept & (in_last | (ptr == LAST_SLOT));
    assign load      = (state == EVAL) & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (frame_end) state_nxt = EVAL;
            EVAL:    if (cnt == '0) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            ptr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        // Early in_last zero-fills the unwritten tail slots on the same edge.
                        for (int unsigned i = 0; i < N_FEAT; i++) begin
                            if (in_last && (3'(i) > ptr)) slots[i] <= '0;
                        end
                        slots[ptr] <= in_feat;
                        if (frame_end) begin
                            ptr   <= '0;
                            cnt   <= LAT_M1;
                            err_q <= ~(in_last & (ptr == LAST_SLOT));
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        slots <= '0;
                        ptr   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign feat_a = slots[0];
    assign feat_b = slots[1];
    assign feat_c = slots[2];
    assign feat_d = slots[3];
    assign feat_e = slots[4];
    assign feat_f = slots[5];

    tnn_result_hold #(
        .IDX_W(IDX_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_class (cls_in),
        .load_err   (err_q),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_class  (out_class),
        .out_err    (out_err),
        .out_idx    (out_idx)
    );

endmodule

// File: tb/tb_tnn_sample_sequencer.sv
// Directed bench: one instance at CLS_LAT=1 and one at CLS_LAT=4 share the clock,
// reset and data inputs; each has its own in_valid.
module tb_tnn_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic [2:0]  in_feat = '0;
    logic        in_last = 1'b0;
    logic        cls_in = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy1, rdy4;
    logic [2:0]  fa1, fb1, fc1, fd1, fe1, ff1;
    logic [2:0]  fa4, fb4, fc4, fd4, fe4, ff4;
    logic        ov1, oc1, oe1, ov4, oc4, oe4;
    logic [15:0] oi1, oi4;
    logic [17:0] vec1, vec4;

    int passed = 0;
    int total  = 0;

    assign vec1 = {fa1, fb1, fc1, fd1, fe1, ff1};
    assign vec4 = {fa4, fb4, fc4, fd4, fe4, ff4};

    always #5 clk = ~clk;

    tnn_sample_sequencer #(.CLS_LAT(1), .IDX_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_feat(in_feat),
        .in_last(in_last), .feat_a(fa1), .feat_b(fb1), .feat_c(fc1), .feat_d(fd1),
        .feat_e(fe1), .feat_f(ff1), .cls_in(cls_in), .out_valid(ov1), .out_ready(out_ready),
        .out_class(oc1), .out_err(oe1), .out_idx(oi1)
    );

    tnn_sample_sequencer #(.CLS_LAT(4), .IDX_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_feat(in_feat),
        .in_last(in_last), .feat_a(fa4), .feat_b(fb4), .feat_c(fc4), .feat_d(fd4),
        .feat_e(fe4), .feat_f(ff4), .cls_in(cls_in), .out_valid(ov4), .out_ready(out_ready),
        .out_class(oc4), .out_err(oe4), .out_idx(oi4)
    );

    task automatic beat(input bit d4, input logic [2:0] f, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (((d4 ? rdy4 : rdy1) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 40) $display("FAIL beat_ready: in_ready got 0 required 1");
        else passed++;
        in_feat = f;
        in_last = l;
        if (d4) v4 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic send6(input bit d4, input logic [17:0] vals, input logic last6);
        for (int i = 0; i < 6; i++) beat(d4, vals[17-3*i -: 3], (i == 5) ? last6 : 1'b0);
    endtask

    task automatic wait_out1(output bit ok);
        int n;
        n = 0;
        while (ov1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (ov1 === 1'b1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++; if (rdy1 !== 1'b0) $display("FAIL rst_in_ready: got %0b required 0", rdy1); else passed++;
        total++; if (ov1 !== 1'b0 || oc1 !== 1'b0 || oe1 !== 1'b0)
            $display("FAIL rst_out: valid/class/err got %0b%0b%0b required 000", ov1, oc1, oe1); else passed++;
        total++; if (oi1 !== 16'd0) $display("FAIL rst_idx: got %0d required 0", oi1); else passed++;
        total++; if (vec1 !== 18'o000000) $display("FAIL rst_feat: got %o required 000000", vec1); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1)
            $display("FAIL rst_release_ready: got %0b%0b required 11", rdy1, rdy4); else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        cls_in = 1'b1;
        out_ready = 1'b1;
        send6(1'b0, 18'o314152, 1'b1);
        @(negedge clk);
        total++; if (ov1 !== 1'b0) $display("FAIL basic_early: out_valid got %0b required 0", ov1); else passed++;
        @(negedge clk);
        total++; if (ov1 !== 1'b1) $display("FAIL basic_valid: got %0b required 1", ov1); else passed++;
        total++; if (vec1 !== 18'o314152) $display("FAIL basic_feat: got %o required 314152", vec1); else passed++;
        total++; if (oc1 !== 1'b1 || oe1 !== 1'b0)
            $display("FAIL basic_class_err: got %0b%0b required 10", oc1, oe1); else passed++;
        total++; if (oi1 !== 16'd0) $display("FAIL basic_idx: got %0d required 0", oi1); else passed++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (ov1 !== 1'b0 || oi1 !== 16'd1 || vec1 !== 18'o0 || rdy1 !== 1'b1)
            $display("FAIL basic_consume: valid=%0b idx=%0d feat=%o ready=%0b required 0 1 0 1",
                     ov1, oi1, vec1, rdy1); else passed++;
        ok = 1'b1;
    endtask

    task automatic test_short_frame();
        bit ok;
        do_reset();
        cls_in = 1'b0;
        beat(1'b0, 3'd7, 1'b0);
        beat(1'b0, 3'd7, 1'b1);
        wait_out1(ok);
        total++; if (!ok) $display("FAIL short_timeout: out_valid got 0 required 1"); else passed++;
        total++; if (vec1 !== 18'o770000) $display("FAIL short_feat: got %o required 770000", vec1); else passed++;
        total++; if (oe1 !== 1'b1 || oi1 !== 16'd0)
            $display("FAIL short_err_idx: err=%0b idx=%0d required 1 0", oe1, oi1); else passed++;
        consume();
        send6(1'b0, 18'o123456, 1'b1);
        wait_out1(ok);
        total++; if (!ok || oe1 !== 1'b0 || oi1 !== 16'd1 || vec1 !== 18'o123456)
            $display("FAIL short_next: valid=%0b err=%0b idx=%0d feat=%o required 1 0 1 123456",
                     ov1, oe1, oi1, vec1); else passed++;
        consume();
    endtask

    task automatic test_missing_last();
        bit ok;
        do_reset();
        send6(1'b0, 18'o123456, 1'b0);
        wait_out1(ok);
        total++; if (!ok || oe1 !== 1'b1 || oi1 !== 16'd0 || vec1 !== 18'o123456)
            $display("FAIL nolast_result: valid=%0b err=%0b idx=%0d feat=%o required 1 1 0 123456",
                     ov1, oe1, oi1, vec1); else passed++;
        consume();
        beat(1'b0, 3'd5, 1'b0);
        total++; if (vec1 !== 18'o500000) $display("FAIL nolast_slot0: got %o required 500000", vec1); else passed++;
        beat(1'b0, 3'd4, 1'b0);
        beat(1'b0, 3'd3, 1'b0);
        beat(1'b0, 3'd2, 1'b0);
        beat(1'b0, 3'd1, 1'b0);
        beat(1'b0, 3'd0, 1'b1);
        wait_out1(ok);
        total++; if (!ok || oe1 !== 1'b0 || oi1 !== 16'd1 || vec1 !== 18'o543210)
            $display("FAIL nolast_next: valid=%0b err=%0b idx=%0d feat=%o required 1 0 1 543210",
                     ov1, oe1, oi1, vec1); else passed++;
        consume();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        cls_in = 1'b0;
        send6(1'b0, 18'o012345, 1'b1);
        wait_out1(ok);
        stable = ok;
        for (int i = 0; i < 20; i++) begin
            if (ov1 !== 1'b1 || oc1 !== 1'b0 || oe1 !== 1'b0 || oi1 !== 16'd2 ||
                rdy1 !== 1'b0 || vec1 !== 18'o012345) stable = 1'b0;
            cls_in = ~cls_in;
            @(negedge clk);
        end
        total++; if (!stable)
            $display("FAIL bp_stable: valid=%0b class=%0b err=%0b idx=%0d ready=%0b required 1 0 0 2 0",
                     ov1, oc1, oe1, oi1, rdy1); else passed++;
        consume();
        total++; if (ov1 !== 1'b0 || oi1 !== 16'd3 || rdy1 !== 1'b1)
            $display("FAIL bp_consume: valid=%0b idx=%0d ready=%0b required 0 3 1", ov1, oi1, rdy1); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (ov1 !== 1'b0 || oi1 !== 16'd3)
            $display("FAIL bp_single: valid=%0b idx=%0d required 0 3", ov1, oi1); else passed++;
    endtask

    task automatic test_latency();
        cls_in = 1'b0;
        send6(1'b1, 18'o765432, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        cls_in = 1'b1;
        total++; if (ov4 !== 1'b0) $display("FAIL lat_early: out_valid got %0b required 0", ov4); else passed++;
        @(posedge clk);
        #1;
        total++; if (ov4 !== 1'b1 || oc4 !== 1'b1 || oe4 !== 1'b0 || oi4 !== 16'd0)
            $display("FAIL lat_late1: valid=%0b class=%0b err=%0b idx=%0d required 1 1 0 0",
                     ov4, oc4, oe4, oi4); else passed++;
        consume();
        cls_in = 1'b0;
        send6(1'b1, 18'o111111, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        cls_in = 1'b1;
        total++; if (ov4 !== 1'b1 || oc4 !== 1'b0 || oi4 !== 16'd1)
            $display("FAIL lat_sample0: valid=%0b class=%0b idx=%0d required 1 0 1", ov4, oc4, oi4); else passed++;
        @(negedge clk);
        total++; if (oc4 !== 1'b0) $display("FAIL lat_hold: class got %0b required 0", oc4); else passed++;
        consume();
    endtask

    task automatic test_async_reset();
        bit ok;
        cls_in = 1'b1;
        send6(1'b0, 18'o777777, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0 || vec1 !== 18'o0 || rdy1 !== 1'b0)
            $display("FAIL arst_eval: valid=%0b feat=%o ready=%0b required 0 0 0", ov1, vec1, rdy1); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send6(1'b0, 18'o246135, 1'b1);
        wait_out1(ok);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ov1 !== 1'b0 || vec1 !== 18'o0 || oi1 !== 16'd0)
            $display("FAIL arst_hold: valid=%0b feat=%o idx=%0d required 0 0 0", ov1, vec1, oi1); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        cls_in = 1'b0;
        send6(1'b0, 18'o321000, 1'b1);
        wait_out1(ok);
        total++; if (!ok || oi1 !== 16'd0 || oc1 !== 1'b0 || oe1 !== 1'b0)
            $display("FAIL arst_next: valid=%0b idx=%0d class=%0b err=%0b required 1 0 0 0",
                     ov1, oi1, oc1, oe1); else passed++;
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_frame();
        test_missing_last();
        test_backpressure();
        test_latency();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tnn_sample_sequencer.md
Name: tnn_sample_sequencer

Overview:
- Front-end driver for the evolved 6x3-bit approximate TNN classifier cores: one instance per core.
- Accepts a stream of 3-bit quantised features over valid/ready and assembles a six-feature vector.
- Drives that vector onto the core's inputs, waits the core's evaluation latency, then samples the core's 1-bit decision.
- Returns the decision downstream over valid/ready, tagged with a sample index and a framing-error flag.

Parameters:
- N_FEAT, 6, features per vector; fixed by the core interface; RTL supports only 6.
- FEAT_W, 3, feature width in bits.
- CLS_LAT, 1, cycles from last feature accept to decision sample; legal range 1..15.
- IDX_W, 16, sample index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  feature beat accepted when in_valid & in_ready.
- in_feat  in  FEAT_W  quantised feature value.
- in_last  in  1  marks final feature of a sample.
- feat_a .. feat_f  out  FEAT_W each  vector slots 0..5, wired to core input_a .. input_f.
- cls_in  in  1  core decision (core cgp_out).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_class  out  1  sampled decision.
- out_err  out  1  framing error for this sample.
- out_idx  out  IDX_W  sample index, 0 for the first sample after reset.

Behaviour:
- Reset (async assert, sync release):
  - state=COLLECT, slot pointer=0, all feat_* = 0.
  - out_valid=0, out_class=0, out_err=0, out_idx=0.
  - in_ready=0 while rst_n low.
- COLLECT:
  - in_ready=1.
  - Each accepted beat writes in_feat into the slot at the pointer and increments the pointer.
  - Beat at slot 5 with in_last=1: normal end, go to EVAL with err=0.
  - Beat at slot 5 with in_last=0: go to EVAL with err=1. The next beat starts a new sample; no resynchronisation.
  - Beat at slot k<5 with in_last=1: slots k+1..5 are forced to 0 on that same edge; go to EVAL with err=1.
- EVAL:
  - in_ready=0.
  - A down-counter loads CLS_LAT-1 on entry.
  - When the counter is 0, cls_in is registered into out_class on that edge; state goes to HOLD and out_valid rises the same edge.
  - The decision is therefore sampled on the CLS_LAT-th rising edge after the accepting edge; out_valid is visible CLS_LAT cycles after the last accept.
  - feat_* stay stable throughout EVAL and HOLD.
- HOLD:
  - in_ready=0.
  - out_valid, out_class, out_err and out_idx are held stable until out_ready.
  - On the consuming edge:
    - out_valid falls.
    - out_idx increments, wrapping from 2^IDX_W-1 to 0.
    - All slots clear to 0 and the pointer resets to 0.
    - state=COLLECT.
  - The earliest next accept is the following edge: no beat is accepted on the consume edge.
- Handshake rules:
  - out_valid never drops without a consume.
  - in_valid without in_ready is ignored; in_feat/in_last are don't-care when in_valid=0.
  - out_ready is ignored when out_valid=0.
- Throughput: at most one sample per N_FEAT + CLS_LAT + 1 cycles.
- Reset mid-operation: abandons any partial or pending sample; out_idx returns to 0.
- Width: feature values pass through unmodified, with no saturation or arithmetic.

Decomposition:
- Shared package tnn_pkg:
  - FEAT_W and N_FEAT constants.
  - Feature vector typedef (array of N_FEAT FEAT_W-bit features).
  - State enum {COLLECT, EVAL, HOLD}.
- One natural sub-module, tnn_result_hold: the output holding register with valid/ready and index counter, reusable by future multi-core voters.
- The slot register file stays inline.

Test Plan:
- Basic sample: beats 3,1,4,1,5,2 with in_last on the 6th, CLS_LAT=1, cls_in tied to 1, out_ready=1 -> feat_a..f = 3,1,4,1,5,2; out_valid one cycle after the 6th accept; out_class=1, out_err=0, out_idx=0.
- Short frame: beats 7,7 with in_last on the 2nd -> feat_c..f=0, out_err=1, out_idx=0; a following good frame gives out_idx=1, out_err=0.
- Missing last: six beats with in_last=0 throughout -> out_err=1; the 7th beat lands in slot 0 of the next sample.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0 throughout; out_ready pulse consumes exactly one result; in_ready returns the next cycle.
- Latency: CLS_LAT=4, with cls_in driven 0 until 3 edges after the last accept and 1 from then on -> out_class=1; with cls_in changing only after the 4th edge -> out_class=0.
- Async reset asserted during EVAL and during HOLD -> out_valid=0, feat_*=0 immediately; next sample reports out_idx=0.
